// File: rtl/aluu_aria_mitra.sv
// aluu_aria_mitra: 4-bit registered ALU on the Tiny Tapeout pin set.
// Define ALUU_DIVMOD_EN to turn opcode 15 from CMP into DIVMOD.
module aluu_aria_mitra (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    logic [3:0] a, b, op, diff;
    logic [4:0] sum, inc;
    logic [6:0] shl, shr;
    logic [7:0] r, r_q;
    logic       c, v, n, z;
    logic [3:0] flags_q;
    logic       unused_bits;

    assign a  = ui_in[7:4];
    assign b  = ui_in[3:0];
    assign op = uio_in[3:0];
    assign unused_bits = ^uio_in[7:4];
    assign sum  = {1'b0, a} + {1'b0, b};
    assign inc  = {1'b0, a} + 5'd1;
    assign diff = a - b;
    // Widened shifts leave the last bit shifted out at a fixed position (0 for amount 0)
    assign shl = {3'b0, a} << b[1:0];
    assign shr = {a, 3'b0} >> b[1:0];

    always_comb begin
        r = 8'h00;
        c = 1'b0;
        v = 1'b0;
        case (op)
            4'd0: begin
                r = {3'b0, sum};
                c = sum[4];
                v = (a[3] == b[3]) && (sum[3] != a[3]);
            end
            4'd1: begin
                r = {4'b0, diff};
                c = a < b;
                v = (a[3] != b[3]) && (diff[3] != a[3]);
            end
            4'd2:  r = {4'b0, a & b};
            4'd3:  r = {4'b0, a | b};
            4'd4:  r = {4'b0, a ^ b};
            4'd5:  r = {4'b0, ~a};
            4'd6:  r = {4'b0, ~(a & b)};
            4'd7:  r = {4'b0, ~(a | b)};
            4'd8:  r = {4'b0, ~(a ^ b)};
            4'd9: begin
                r = {4'b0, shl[3:0]};
                c = shl[4];
            end
            4'd10: begin
                r = {4'b0, shr[6:3]};
                c = shr[2];
            end
            4'd11: r = {4'b0, a[2:0], a[3]};
            4'd12: r = {4'b0, a[0], a[3:1]};
            4'd13: r = {4'b0, a} * {4'b0, b};
            4'd14: begin
                r = {3'b0, inc};
                c = inc[4];
                v = !a[3] && inc[3];
            end
            default: begin
`ifdef ALUU_DIVMOD_EN
                r = (b == 4'd0) ? 8'hFF : {a % b, a / b};
                v = b == 4'd0;
`else
                r = {5'b0, a > b, a == b, a < b};
`endif
            end
        endcase
    end

    assign n = (op == 4'd13) ? r[7] : r[3];
    assign z = r == 8'h00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q     <= 8'h00;
            flags_q <= 4'h0;
        end else if (ena) begin
            r_q     <= r;
            flags_q <= {c, z, n, v};
        end
    end

    assign uo_out  = r_q;
    assign uio_out = {flags_q, 4'b0};
    assign uio_oe  = 8'hF0;
endmodule

// File: tb/tb_aluu_aria_mitra.sv
// tb_aluu_aria_mitra: directed vector table plus reset/hold sequences for aluu_aria_mitra.
module tb_aluu_aria_mitra;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'hFF;
    logic [7:0] uio_in = 8'h0D;
    logic [7:0] uo_out, uio_out, uio_oe;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] ui;
        logic [3:0] op;
        logic [7:0] r;
        logic [7:0] f;
    } vec_t;
    vec_t vecs[$];

    aluu_aria_mitra dut (
        .clk(clk), .rst(rst), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic [7:0] ui, input logic [3:0] op);
        ui_in = ui;
        uio_in = {4'hA, op};
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs.push_back('{8'h98, 4'd0,  8'h11, 8'h90});
        vecs.push_back('{8'hFF, 4'd0,  8'h1E, 8'hA0});
        vecs.push_back('{8'h00, 4'd0,  8'h00, 8'h40});
        vecs.push_back('{8'h71, 4'd0,  8'h08, 8'h30});
        vecs.push_back('{8'h35, 4'd1,  8'h0E, 8'hA0});
        vecs.push_back('{8'h55, 4'd1,  8'h00, 8'h40});
        vecs.push_back('{8'h81, 4'd1,  8'h07, 8'h10});
        vecs.push_back('{8'hA5, 4'd2,  8'h00, 8'h40});
        vecs.push_back('{8'hA5, 4'd3,  8'h0F, 8'h20});
        vecs.push_back('{8'hCA, 4'd4,  8'h06, 8'h00});
        vecs.push_back('{8'h3F, 4'd5,  8'h0C, 8'h20});
        vecs.push_back('{8'hFF, 4'd6,  8'h00, 8'h40});
        vecs.push_back('{8'h00, 4'd7,  8'h0F, 8'h20});
        vecs.push_back('{8'h55, 4'd8,  8'h0F, 8'h20});
        vecs.push_back('{8'hB2, 4'd9,  8'h0C, 8'h20});
        vecs.push_back('{8'h63, 4'd9,  8'h00, 8'hC0});
        vecs.push_back('{8'h94, 4'd9,  8'h09, 8'h20});
        vecs.push_back('{8'h91, 4'd10, 8'h04, 8'h80});
        vecs.push_back('{8'h9C, 4'd10, 8'h09, 8'h20});
        vecs.push_back('{8'h90, 4'd11, 8'h03, 8'h00});
        vecs.push_back('{8'h90, 4'd12, 8'h0C, 8'h20});
        vecs.push_back('{8'hFF, 4'd13, 8'hE1, 8'h20});
        vecs.push_back('{8'h82, 4'd13, 8'h10, 8'h00});
        vecs.push_back('{8'hF0, 4'd14, 8'h10, 8'h80});
        vecs.push_back('{8'h70, 4'd14, 8'h08, 8'h30});
`ifdef ALUU_DIVMOD_EN
        vecs.push_back('{8'h72, 4'd15, 8'h13, 8'h00});
        vecs.push_back('{8'h55, 4'd15, 8'h01, 8'h00});
        vecs.push_back('{8'h29, 4'd15, 8'h20, 8'h00});
        vecs.push_back('{8'h70, 4'd15, 8'hFF, 8'h30});
`else
        vecs.push_back('{8'h72, 4'd15, 8'h04, 8'h00});
        vecs.push_back('{8'h55, 4'd15, 8'h02, 8'h00});
        vecs.push_back('{8'h29, 4'd15, 8'h01, 8'h00});
        vecs.push_back('{8'h70, 4'd15, 8'h04, 8'h00});
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("reset uo_out", uo_out, 8'h00);
        chk("reset uio_out", uio_out, 8'h00);
        chk("reset uio_oe", uio_oe, 8'hF0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("first edge uo_out", uo_out, 8'hE1);
        chk("first edge uio_out", uio_out, 8'h20);

        foreach (vecs[i]) begin
            step(vecs[i].ui, vecs[i].op);
            chk($sformatf("vec%0d uo_out", i), uo_out, vecs[i].r);
            chk($sformatf("vec%0d uio_out", i), uio_out, vecs[i].f);
            chk($sformatf("vec%0d uio_oe", i), uio_oe, 8'hF0);
        end

        step(8'h98, 4'd0);
        chk("pre-hold uo_out", uo_out, 8'h11);
        ena = 1'b0;
        ui_in = 8'h11;
        uio_in = 8'h0D;
        repeat (3) @(posedge clk);
        #1;
        chk("hold uo_out", uo_out, 8'h11);
        chk("hold uio_out", uio_out, 8'h90);
        ena = 1'b1;
        step(8'h11, 4'd13);
        chk("resume uo_out", uo_out, 8'h01);
        chk("resume uio_out", uio_out, 8'h00);

        step(8'hFF, 4'd13);
        chk("pre-reset uo_out", uo_out, 8'hE1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async reset uo_out", uo_out, 8'h00);
        chk("async reset uio_out", uio_out, 8'h00);
        @(posedge clk);
        #1;
        chk("reset held uo_out", uo_out, 8'h00);
        ui_in = 8'h35;
        uio_in = 8'h01;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post-reset uo_out", uo_out, 8'h0E);
        chk("post-reset uio_out", uio_out, 8'hA0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
